// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
//
// Purpose: FSM state encoding, default reset PC and the instruction alignment mask
//          used by fetch_sequencer and fetch_buffer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Low PC bits that must be zero for a 4-byte aligned instruction fetch.
  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry {instr, pc} holding register towards decode
//
// Purpose: holds one fetched instruction until decode takes it (o_valid & i_ready).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_load              capture i_instr/i_pc (only issued when entry is empty or draining)
//   i_instr, i_pc       instruction word and its PC
//   i_flush             drop the entry (control-flow change); wins over i_load
//   i_ready             decode accepts the entry
//   o_valid, o_instr, o_pc  entry presented to decode, stable while not accepted
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC register and single-outstanding instruction fetch FSM
//
// Purpose: issues one imem request at a time from the PC, delivers responses to decode
//          through fetch_buffer, applies redirects/traps and drops stale responses.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req_valid/addr/ready          fetch request handshake
//   imem_rsp_valid/data                single-cycle fetch response
//   if_valid/instr/pc/ready            instruction handed to decode
//   redirect_valid/pc, trap_valid/vector  control-flow changes (trap has priority)
//   pc_misaligned                      one-cycle pulse after a target with nonzero [1:0]
//   current_pc                         address of the next or outstanding fetch
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            pc_misaligned,
  output logic [XLEN-1:0] current_pc
);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] r_pc;
  logic            r_misaligned;

  logic            w_buf_valid;
  logic            w_req_valid;
  logic            w_req_hs;
  logic            w_ctrl;
  logic [XLEN-1:0] w_target;
  logic            w_rsp_live;

  // A request is only offered when the buffer is empty or being drained this cycle,
  // so the response can always be captured when it returns.
  assign w_req_valid = (r_state == REQ) && (!w_buf_valid || if_ready);
  assign w_req_hs    = w_req_valid && imem_req_ready;

  // Control flow is ignored in IDLE; trap wins over redirect.
  assign w_ctrl      = (r_state != IDLE) && (trap_valid || redirect_valid);
  assign w_target    = trap_valid ? trap_vector : redirect_pc;

  // A response in the same cycle as a control-flow change belongs to the old path.
  assign w_rsp_live  = (r_state == WAIT) && imem_rsp_valid && !w_ctrl;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: w_next_state = REQ;
      REQ: begin
        if (w_ctrl)        w_next_state = w_req_hs ? FLUSH : REQ;
        else if (w_req_hs) w_next_state = WAIT;
      end
      WAIT: begin
        if (w_ctrl)              w_next_state = imem_rsp_valid ? REQ : FLUSH;
        else if (imem_rsp_valid) w_next_state = REQ;
      end
      FLUSH: begin
        // The stale response retires the flush even if another redirect lands with it.
        if (imem_rsp_valid) w_next_state = REQ;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_misaligned <= w_ctrl && (|(w_target[1:0] & INSTR_ALIGN_MASK));
      if (w_ctrl)
        r_pc <= w_target & ~XLEN'(INSTR_ALIGN_MASK);
      else if (w_rsp_live)
        r_pc <= r_pc + XLEN'(4);
    end
  end

  fetch_buffer #(.XLEN(XLEN)) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_rsp_live),
    .i_instr (imem_rsp_data),
    .i_pc    (r_pc),
    .i_flush (w_ctrl),
    .i_ready (if_ready),
    .o_valid (w_buf_valid),
    .o_instr (if_instr),
    .o_pc    (if_pc)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = w_buf_valid;
  assign pc_misaligned  = r_misaligned;
  assign current_pc     = r_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        pc_misaligned;
  logic [31:0] current_pc;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .pc_misaligned(pc_misaligned), .current_pc(current_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Memory model state
  int          mem_cnt = 0;
  int          mem_lat_max = 1;
  bit          mem_busy = 1'b0;
  bit          mem_hold = 1'b0;
  logic [31:0] mem_addr = '0;

  // Program-order reference: next PC decode should see
  logic [31:0] exp_pc = RST_PC;
  bit          prev_ctrl = 1'b0;
  bit          prev_mis = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] dec_log[$];
  int          dec_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic monitor();
    bit          req_hs, dec_hs, ctrl;
    logic [31:0] tgt, exp_req;
    if (!rst_n) begin
      exp_pc = RST_PC; prev_ctrl = 0; prev_mis = 0; prev_stall = 0;
      mem_cnt = 0; mem_busy = 0;
      return;
    end
    req_hs = imem_req_valid && imem_req_ready;
    dec_hs = if_valid && if_ready;
    ctrl   = trap_valid || redirect_valid;
    tgt    = trap_valid ? trap_vector : redirect_pc;

    n_tests++;
    if (pc_misaligned !== prev_mis) begin
      n_fail++; $display("FAIL mon_misaligned cyc=%0d got=%0b want=%0b", cyc, pc_misaligned, prev_mis);
    end
    if (prev_ctrl) begin
      n_tests++;
      if (if_valid !== 1'b0) begin
        n_fail++; $display("FAIL mon_flush_ifvalid cyc=%0d got=%0b want=0", cyc, if_valid);
      end
    end
    if (prev_stall) begin
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
        n_fail++; $display("FAIL mon_stall_hold cyc=%0d got=%0b/%h/%h want=1/%h/%h",
                           cyc, if_valid, if_pc, if_instr, prev_pc, prev_instr);
      end
    end
    if (if_valid) begin
      n_tests++;
      if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
        n_fail++; $display("FAIL mon_if_data cyc=%0d got=%h/%h want=%h/%h",
                           cyc, if_pc, if_instr, exp_pc, mem_word(exp_pc));
      end
    end
    if (req_hs) begin
      n_tests++;
      if (mem_busy) begin
        n_fail++; $display("FAIL mon_one_outstanding cyc=%0d got=2 outstanding want=1", cyc);
      end
      if (!ctrl) begin
        exp_req = dec_hs ? exp_pc + 32'd4 : exp_pc;
        n_tests++;
        if (if_valid && !dec_hs) begin
          n_fail++; $display("FAIL mon_req_while_full cyc=%0d got=req want=no req", cyc);
        end
        n_tests++;
        if (imem_req_addr !== exp_req || current_pc !== exp_req) begin
          n_fail++; $display("FAIL mon_req_addr cyc=%0d got=%h/%h want=%h",
                             cyc, imem_req_addr, current_pc, exp_req);
        end
      end
      req_log.push_back(imem_req_addr); req_cyc.push_back(cyc);
      mem_busy = 1; mem_addr = imem_req_addr; mem_cnt = $urandom_range(mem_lat_max, 1);
    end
    if (dec_hs) begin
      dec_log.push_back(if_pc); dec_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
    prev_ctrl  = ctrl;
    prev_mis   = ctrl && (tgt[1:0] != 2'b00);
    if (ctrl) exp_pc = tgt & 32'hFFFF_FFFC;
    prev_stall = if_valid && !if_ready && !ctrl;
    prev_pc    = if_pc;
    prev_instr = if_instr;
  endtask

  // One cycle: observe the current cycle, then move to the next negedge and drive the memory.
  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
    if (mem_cnt > 0 && !mem_hold) mem_cnt--;
    if (mem_busy && mem_cnt == 0 && !mem_hold) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_addr); mem_busy = 0;
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
  endtask

  task automatic wait_req(output bit seen);
    int n = 0;
    #1;
    while (!imem_req_valid && n < 32) begin tick(); #1; n++; end
    seen = imem_req_valid;
  endtask

  task automatic wait_ifv(output bit seen);
    int n = 0;
    #1;
    while (!if_valid && n < 32) begin tick(); #1; n++; end
    seen = if_valid;
  endtask

  task automatic do_reset(input bit rdy, input bit dec_rdy);
    rst_n = 1'b0;
    redirect_valid = 0; trap_valid = 0; mem_hold = 0; mem_lat_max = 1;
    imem_req_ready = rdy; if_ready = dec_rdy;
    tick(); tick();
    rst_n = 1'b1;
    req_log.delete(); req_cyc.delete(); dec_log.delete(); dec_cyc.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || if_valid !== 1'b0 || if_instr !== 32'h0 ||
        if_pc !== 32'h0 || pc_misaligned !== 1'b0 || current_pc !== RST_PC) begin
      n_fail++; $display("FAIL reset_values got=%0b/%h/%0b/%h/%h/%0b/%h want=0/%h/0/0/0/0/%h",
                         imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, pc_misaligned,
                         current_pc, RST_PC, RST_PC);
    end
    @(negedge clk);
    do_reset(1'b0, 1'b1);
    #1;
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_cycle got=%0b want=0", imem_req_valid);
    end
    tick(); #1;
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_first_req got=%0b/%h want=1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1);
    repeat (8) tick();
    n_tests++;
    if (req_log.size() < 3) begin
      n_fail++; $display("FAIL stream_req_count got=%0d want>=3", req_log.size());
    end else begin
      n_tests++;
      if (req_log[0] !== 32'h8000_0000 || req_log[1] !== 32'h8000_0004 || req_log[2] !== 32'h8000_0008) begin
        n_fail++; $display("FAIL stream_addrs got=%h,%h,%h want=80000000,80000004,80000008",
                           req_log[0], req_log[1], req_log[2]);
      end
      n_tests++;
      if (req_cyc[1] - req_cyc[0] != 2 || req_cyc[2] - req_cyc[1] != 2) begin
        n_fail++; $display("FAIL stream_spacing got=%0d,%0d want=2,2", req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1]);
      end
    end
    n_tests++;
    if (dec_log.size() < 2 || req_log.size() < 1) begin
      n_fail++; $display("FAIL stream_dec_count got=%0d want>=2", dec_log.size());
    end else begin
      n_tests++;
      if (dec_log[0] !== 32'h8000_0000 || dec_log[1] !== 32'h8000_0004 || dec_cyc[0] != req_cyc[0] + 2) begin
        n_fail++; $display("FAIL stream_dec got=%h,%h lat=%0d want=80000000,80000004 lat=2",
                           dec_log[0], dec_log[1], dec_cyc[0] - req_cyc[0]);
      end
    end
  endtask

  task automatic test_stall();
    bit seen; int n; logic [31:0] cap_pc, cap_instr;
    wait_ifv(seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL stall_setup got=timeout want=if_valid"); return; end
    if_ready = 1'b0;
    cap_pc = if_pc; cap_instr = if_instr; n = req_log.size();
    repeat (5) begin
      tick(); #1;
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== cap_pc || if_instr !== cap_instr || req_log.size() != n) begin
        n_fail++; $display("FAIL stall_hold got=%0b/%h/%h reqs=%0d want=1/%h/%h reqs=%0d",
                           if_valid, if_pc, if_instr, req_log.size(), cap_pc, cap_instr, n);
      end
    end
    if_ready = 1'b1;
    tick();
    n_tests++;
    if (req_log.size() != n + 1 || req_log[req_log.size() - 1] !== cap_pc + 32'd4) begin
      n_fail++; $display("FAIL stall_release got=reqs %0d want=reqs %0d addr %h", req_log.size(), n + 1, cap_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_flush();
    bit seen;
    do_reset(1'b1, 1'b1);
    wait_req(seen);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000; if_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    #1;
    n_tests++;
    if (!seen || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL redirect_flush_state got=%0b/%0b want=0/0", imem_req_valid, if_valid);
    end
    tick(); #1;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000) begin
      n_fail++; $display("FAIL redirect_refetch got=%0b/%0b/%h want=0/1/80001000", if_valid, imem_req_valid, imem_req_addr);
    end
    wait_ifv(seen);
    n_tests++;
    if (!seen || if_pc !== 32'h8000_1000 || if_instr !== mem_word(32'h8000_1000)) begin
      n_fail++; $display("FAIL redirect_deliver got=%0b/%h want=1/80001000", seen, if_pc);
    end
  endtask

  task automatic test_trap_priority();
    bit seen;
    do_reset(1'b0, 1'b1);
    wait_req(seen);
    trap_valid = 1'b1; trap_vector = 32'h8000_0100;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000; if_ready = 1'b0;
    tick();
    trap_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    #1;
    n_tests++;
    if (!seen || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100 || current_pc !== 32'h8000_0100) begin
      n_fail++; $display("FAIL trap_priority got=%0b/%h/%h want=1/80000100", imem_req_valid, imem_req_addr, current_pc);
    end
    wait_ifv(seen);
    n_tests++;
    if (!seen || if_pc !== 32'h8000_0100) begin
      n_fail++; $display("FAIL trap_deliver got=%0b/%h want=1/80000100", seen, if_pc);
    end
  endtask

  task automatic test_misaligned();
    bit seen;
    do_reset(1'b0, 1'b1);
    wait_req(seen);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; if_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    #1;
    n_tests++;
    if (!seen || pc_misaligned !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      n_fail++; $display("FAIL misaligned_pulse got=%0b/%0b/%h want=1/1/80000100", pc_misaligned, imem_req_valid, imem_req_addr);
    end
    tick(); #1;
    n_tests++;
    if (pc_misaligned !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_one_cycle got=%0b want=0", pc_misaligned);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    do_reset(1'b1, 1'b1);
    mem_hold = 1'b1;
    wait_req(seen);
    tick(); tick();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(RST_PC);
    #1;
    n_tests++;
    if (!seen || if_valid !== 1'b0 || imem_req_valid !== 1'b0 || current_pc !== RST_PC) begin
      n_fail++; $display("FAIL midwait_reset got=%0b/%0b/%h want=0/0/%h", if_valid, imem_req_valid, current_pc, RST_PC);
    end
    tick();
    mem_hold = 1'b0;
    rst_n = 1'b1;
    req_log.delete(); req_cyc.delete();
    tick(); #1;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_fail++; $display("FAIL midwait_first_req got=%0b/%0b/%h want=0/1/%h", if_valid, imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset(1'b0, 1'b1);
    wait_req(seen);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; if_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
    req_log.delete(); req_cyc.delete(); dec_log.delete(); dec_cyc.delete();
    repeat (6) tick();
    n_tests++;
    if (!seen || req_log.size() < 2 || dec_log.size() < 2) begin
      n_fail++; $display("FAIL wrap_count got=%0d reqs %0d decs want>=2 each", req_log.size(), dec_log.size());
    end else begin
      n_tests++;
      if (req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0 || dec_log[0] !== 32'hFFFF_FFFC || dec_log[1] !== 32'h0) begin
        n_fail++; $display("FAIL wrap_addrs got=%h,%h dec %h,%h want=fffffffc,00000000",
                           req_log[0], req_log[1], dec_log[0], dec_log[1]);
      end
    end
  endtask

  task automatic test_random();
    do_reset(1'b1, 1'b1);
    mem_lat_max = 3;
    tick(); tick();
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      redirect_valid = 1'b0; trap_valid = 1'b0;
      if ($urandom_range(19, 0) == 0) begin
        redirect_valid = $urandom_range(1, 0);
        trap_valid     = !redirect_valid || ($urandom_range(1, 0) == 1);
        redirect_pc    = $urandom;
        trap_vector    = $urandom;
        if_ready       = 1'b0;
      end else begin
        if_ready = ($urandom_range(2, 0) != 0);
      end
      tick();
    end
    redirect_valid = 1'b0; trap_valid = 1'b0;
    tick();
    n_tests++;
    if (dec_log.size() < 50) begin
      n_fail++; $display("FAIL random_progress got=%0d delivered want>=50", dec_log.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_trap_priority();
    test_misaligned();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the program counter and instruction-memory fetch for the core. Owns the PC register, issues one instruction-memory request at a time over a valid/ready handshake, and presents the fetched instruction and its PC to decode through a one-entry output buffer. Applies control-flow redirects and traps from later stages, and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h80000000, PC loaded on reset
- XLEN, 32, address/data width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address (always 4-byte aligned)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid (one cycle, never before the cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_instr  out  32  instruction word
- if_pc  out  XLEN  PC of if_instr
- if_ready  in  1  decode accepts instruction
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  XLEN  redirect target
- trap_valid  in  1  trap taken
- trap_vector  in  XLEN  trap target
- pc_misaligned  out  1  one-cycle pulse: accepted target had [1:0] != 0
- current_pc  out  XLEN  address of next/outstanding fetch

## Operation
- States: IDLE, REQ, WAIT, FLUSH.
- IDLE: entered only from reset; unconditionally -> REQ next cycle.
- REQ: imem_req_valid=1, imem_req_addr=pc. Entered only when output buffer is empty or drains this cycle. Handshake (valid&ready) -> WAIT.
- WAIT: on imem_rsp_valid, buffer <= {rsp_data, pc}, pc <= pc+4 (mod 2^32, wraps 0xFFFFFFFC -> 0), -> REQ if buffer free next cycle, else stay in WAIT-hold until if_ready then -> REQ.
- Control-flow: trap_valid has priority over redirect_valid. Target used is {target[XLEN-1:2], 2'b00}; pc_misaligned pulses if target[1:0] != 0. On either, in any state except IDLE: pc <= target, output buffer invalidated (if_valid=0 next cycle), and:
  - REQ without handshake this cycle -> REQ (request re-driven with new addr next cycle).
  - REQ with handshake this cycle, or WAIT without response this cycle -> FLUSH.
  - WAIT with response this cycle -> response dropped, -> REQ.
  - FLUSH -> stays FLUSH.
- FLUSH: imem_req_valid=0; next imem_rsp_valid dropped, -> REQ.
- Redirect/trap in IDLE is ignored.
- Decode handshake: if_valid&if_ready empties buffer; if_instr/if_pc stable while if_valid & !if_ready.

## Timing
- Reset (async assert, sync release inside clk domain by driver): pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, pc_misaligned=0, current_pc=RESET_PC.
- First request: imem_req_valid high in 2nd cycle after rst_n deasserts.
- Request accepted cycle N, response N+1 -> if_valid N+2, next request N+2. Peak throughput: 1 instruction / 2 cycles.
- Redirect in cycle N with no outstanding request: request to new target in N+1.
- Reset mid-operation: all state cleared immediately; outstanding response after reset ignored (state IDLE/REQ treats imem_rsp_valid as don't-care outside WAIT/FLUSH).
- At most one outstanding memory request at all times.

## Structure
- Shared package fetch_pkg: state enum (IDLE, REQ, WAIT, FLUSH), RESET_PC default, INSTR_ALIGN_MASK constant.
- Sub-module fetch_buffer: one-entry valid/ready register holding {instr, pc} with flush input; sequencer FSM and PC register in top.

## Test plan
- Reset release, imem_req_ready=1, rsp 1 cycle later -> addresses 0x80000000, 0x80000004, 0x80000008 issued every 2 cycles; if_pc matches each.
- Decode stalls (if_ready=0 for 5 cycles) -> if_instr/if_pc held, no new request until if_ready=1.
- redirect_pc=0x80001000 in same cycle as request handshake -> FLUSH, next response dropped, next request to 0x80001000, if_valid never shows stale instr.
- trap_valid (vector 0x80000100) and redirect_valid (0x80002000) together -> fetch at 0x80000100.
- redirect_pc=0x80000102 -> pc_misaligned pulses one cycle, fetch at 0x80000100.
- Reset asserted while in WAIT, response arrives during reset -> if_valid=0, first post-reset request to 0x80000000; PC at 0xFFFFFFFC increments to 0x00000000.
